// File: rtl/data_mux_pkg.sv
// data_mux_pkg: shared write-state enum and sizing constants for data_mux_seq
package data_mux_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, HOLD} wr_state_e;
  localparam int CNT_W = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NSRC = 2;
endpackage

// File: rtl/ext_write_fsm.sv
// ext_write_fsm: external-bus write sequencer (setup, drive, hold, acknowledge)
module ext_write_fsm
  import data_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test1,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] dl,
  output logic [WIDTH-1:0] ext_out,
  output logic             ext_oe,
  output logic             wr_ack,
  output logic             idle
);
  wr_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ext_out_q, ext_out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ext_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ext_out_q <= ext_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_out_d = ext_out_q;
    unique case (state_q)
      IDLE: if (wr_req && !test1) begin
        state_d   = SETUP;
        ext_out_d = dl;
      end
      SETUP: state_d = DRIVE;
      DRIVE: begin
        state_d = HOLD;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        state_d = (cnt_q == '0) ? IDLE : HOLD;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Test1 disconnects the pads, so any write in flight is abandoned
    if (test1 && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ext_out = ext_out_q;
    ext_oe  = (state_q == DRIVE) || (state_q == HOLD);
    wr_ack  = (state_q == HOLD) && (cnt_q == '0) && !test1;
    idle    = (state_q == IDLE);
  end
endmodule

// File: rtl/data_mux_seq.sv
// data_mux_seq: wired-AND internal data bus with keeper, read latch and external write sequencer
module data_mux_seq
  import data_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC = DEF_NSRC,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  Test1,
  input  logic                  Precharge,
  input  logic [NSRC*WIDTH-1:0] SrcData,
  input  logic [NSRC-1:0]       SrcOE,
  input  logic                  ExtToDL,
  input  logic [WIDTH-1:0]      ExtIn,
  output logic [WIDTH-1:0]      ExtOut,
  output logic                  ExtOE,
  input  logic                  WrReq,
  output logic                  WrAck,
  input  logic                  RdReq,
  output logic                  RdValid,
  output logic [WIDTH-1:0]      DL,
  output logic                  Conflict
);
  logic [WIDTH-1:0] dl_q, dl_d, rd_q, rd_d, and_v, or_v;
  logic conflict_q, conflict_d, rd_valid_q, rd_fire, any_v, multi_v, ext_act, idle;

  ext_write_fsm #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES)) u_wr (
    .clk(CLK), .rst(RESET), .test1(Test1), .wr_req(WrReq), .dl(dl_q),
    .ext_out(ExtOut), .ext_oe(ExtOE), .wr_ack(WrAck), .idle(idle)
  );

  always_comb begin
    and_v   = '1;
    or_v    = '0;
    any_v   = 1'b0;
    multi_v = 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (SrcOE[k]) begin
        multi_v = multi_v | any_v;
        any_v   = 1'b1;
        and_v   = and_v & SrcData[k*WIDTH +: WIDTH];
        or_v    = or_v | SrcData[k*WIDTH +: WIDTH];
      end
    ext_act = ExtToDL && !Test1;
    if (ext_act) begin
      multi_v = multi_v | any_v;
      any_v   = 1'b1;
      and_v   = and_v & rd_q;
      or_v    = or_v | rd_q;
    end
    dl_d       = Precharge ? '1 : any_v ? and_v : dl_q;
    conflict_d = !Precharge && multi_v && (or_v != and_v);
    rd_fire    = RdReq && !Test1 && idle && !WrReq;
    rd_d       = rd_fire ? ExtIn : rd_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dl_q       <= '1;
      rd_q       <= '1;
      conflict_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      dl_q       <= dl_d;
      rd_q       <= rd_d;
      conflict_q <= conflict_d;
      rd_valid_q <= rd_fire;
    end
  end

  assign DL       = dl_q;
  assign Conflict = conflict_q;
  assign RdValid  = rd_valid_q;
endmodule

// File: tb/tb_data_mux_seq.sv
// tb_data_mux_seq: directed self-checking bench for data_mux_seq (HOLD_CYCLES = 2)
module tb_data_mux_seq;
  logic CLK = 0, RESET, Test1, Precharge, ExtToDL, WrReq, RdReq;
  logic [15:0] SrcData;
  logic [1:0] SrcOE;
  logic [7:0] ExtIn, ExtOut, DL;
  logic ExtOE, WrAck, RdValid, Conflict;
  int checks = 0, errors = 0;

  data_mux_seq #(.WIDTH(8), .NSRC(2), .HOLD_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .Test1(Test1), .Precharge(Precharge),
    .SrcData(SrcData), .SrcOE(SrcOE), .ExtToDL(ExtToDL), .ExtIn(ExtIn),
    .ExtOut(ExtOut), .ExtOE(ExtOE), .WrReq(WrReq), .WrAck(WrAck),
    .RdReq(RdReq), .RdValid(RdValid), .DL(DL), .Conflict(Conflict)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1; Test1 = 0; Precharge = 0; ExtToDL = 0; WrReq = 0; RdReq = 0;
    SrcData = '0; SrcOE = '0; ExtIn = '0;
    step(); step();
    chk("rst_dl", DL, 8'hFF);
    chk("rst_extoe", ExtOE, 0);
    chk("rst_extout", ExtOut, 0);
    chk("rst_wrack", WrAck, 0);
    chk("rst_rdvalid", RdValid, 0);
    chk("rst_conflict", Conflict, 0);
    RESET = 0;
    repeat (5) step();
    chk("keeper_idle", DL, 8'hFF);
    // wired-AND with disagreement
    SrcData = {8'h3C, 8'hF0}; SrcOE = 2'b11;
    step();
    chk("and_dl", DL, 8'h30);
    chk("and_conflict", Conflict, 1);
    SrcData = {8'hF0, 8'hF0};
    step();
    chk("agree_dl", DL, 8'hF0);
    chk("agree_conflict", Conflict, 0);
    SrcData = {8'h00, 8'hA5}; SrcOE = 2'b01;
    step();
    chk("single_dl", DL, 8'hA5);
    SrcOE = 2'b00;
    // write with HOLD_CYCLES = 2
    WrReq = 1;
    step();
    WrReq = 0;
    chk("wr_setup_extout", ExtOut, 8'hA5);
    chk("wr_setup_extoe", ExtOE, 0);
    step();
    chk("wr_drive_extoe", ExtOE, 1);
    chk("wr_drive_ack", WrAck, 0);
    step();
    chk("wr_hold1_extoe", ExtOE, 1);
    chk("wr_hold1_ack", WrAck, 0);
    step();
    chk("wr_hold2_extoe", ExtOE, 1);
    chk("wr_hold2_ack", WrAck, 1);
    step();
    chk("wr_done_extoe", ExtOE, 0);
    chk("wr_done_ack", WrAck, 0);
    chk("keeper_after_wr", DL, 8'hA5);
    Precharge = 1;
    step();
    Precharge = 0;
    chk("precharge_dl", DL, 8'hFF);
    // abort in DRIVE
    WrReq = 1;
    step();
    WrReq = 0;
    step();
    chk("abort_drive_extoe", ExtOE, 1);
    Test1 = 1;
    step();
    chk("abort_extoe", ExtOE, 0);
    chk("abort_ack", WrAck, 0);
    chk("abort_extout", ExtOut, 8'hFF);
    step();
    chk("abort_ack2", WrAck, 0);
    chk("abort_extoe2", ExtOE, 0);
    RdReq = 1; ExtIn = 8'h99;
    step();
    RdReq = 0;
    chk("test1_rd_blocked", RdValid, 0);
    Test1 = 0;
    // read then ext-to-DL
    ExtIn = 8'h5A; RdReq = 1;
    step();
    RdReq = 0;
    chk("rd_valid", RdValid, 1);
    ExtToDL = 1;
    step();
    chk("rd_dl", DL, 8'h5A);
    chk("rd_valid_pulse", RdValid, 0);
    // Test1 masks the latch from the bus
    Test1 = 1; SrcOE = 2'b01; SrcData = {8'h00, 8'h0F};
    step();
    chk("test1_mask_dl", DL, 8'h0F);
    chk("test1_mask_conflict", Conflict, 0);
    Test1 = 0;
    step();
    chk("ext_src_dl", DL, 8'h0A);
    chk("ext_src_conflict", Conflict, 1);
    ExtToDL = 0; SrcOE = 2'b00;
    // simultaneous read and write: write wins
    ExtIn = 8'h33; RdReq = 1; WrReq = 1;
    step();
    WrReq = 0; RdReq = 0;
    chk("rw_no_rdvalid", RdValid, 0);
    chk("rw_extout", ExtOut, 8'h0A);
    RdReq = 1; ExtIn = 8'h77;
    step();
    RdReq = 0;
    chk("rd_busy_ignored", RdValid, 0);
    chk("rw_drive_extoe", ExtOE, 1);
    step();
    chk("rw_hold1_ack", WrAck, 0);
    step();
    chk("rw_hold2_ack", WrAck, 1);
    step();
    ExtToDL = 1;
    step();
    ExtToDL = 0;
    chk("latch_unchanged", DL, 8'h5A);
    // reset during HOLD
    WrReq = 1;
    step();
    WrReq = 0;
    step();
    step();
    chk("rst_hold_extoe_pre", ExtOE, 1);
    RESET = 1;
    step();
    chk("rst_hold_extoe", ExtOE, 0);
    chk("rst_hold_ack", WrAck, 0);
    chk("rst_hold_dl", DL, 8'hFF);
    chk("rst_hold_extout", ExtOut, 0);
    RESET = 0;
    step();
    chk("post_rst_ack", WrAck, 0);
    chk("post_rst_extoe", ExtOE, 0);
    WrReq = 1;
    step();
    WrReq = 0;
    chk("post_rst_setup_extoe", ExtOE, 0);
    step();
    chk("post_rst_drive_extoe", ExtOE, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
